// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central hazard controller for a five-stage pipeline. Each cycle one
//   control mode is chosen combinationally from the cache stalls and a
//   load-use check. The per-register write, hold, nop and flush enables are
//   decoded from that mode with zero latency. The mode is also registered,
//   and saturating performance counters plus a sticky stall-timeout flag
//   track stall behaviour.
//
// Ports
//   clk, rst_n                 clock; synchronous active-low reset
//   ID_rs, ID_rt, ID_uses_rt   source registers of the instruction in ID
//   EX_CacheRead, EX_rt        load in EX and its destination register
//   branch_taken               branch/jump resolved taken in ID
//   ICache_stall, DCache_stall cache miss in progress
//   PCWrite, IFIDWrite         PC / IF-ID update enables
//   IFID_flush                 IF/ID loads a nop
//   IDEX_hold, IDEX_nop        ID/EX keeps contents / control zeroed
//   EXMEM_hold, MEMWB_hold     later pipeline registers keep contents
//   mode_q                     registered mode (0 RUN,1 DFREEZE,2 IFREEZE,3 BUBBLE)
//   stall_cnt, bubble_cnt, flush_cnt   saturating event counters
//   stall_timeout              sticky: consecutive freeze cycles hit TIMEOUT
module pipeline_hazard_ctrl #(
   parameter int TIMEOUT = 1023,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       ID_rs,
   input  logic [4:0]       ID_rt,
   input  logic             ID_uses_rt,
   input  logic             EX_CacheRead,
   input  logic [4:0]       EX_rt,
   input  logic             branch_taken,
   input  logic             ICache_stall,
   input  logic             DCache_stall,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IFID_flush,
   output logic             IDEX_hold,
   output logic             IDEX_nop,
   output logic             EXMEM_hold,
   output logic             MEMWB_hold,
   output logic [1:0]       mode_q,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             stall_timeout
);

   typedef enum logic [1:0] {
      MODE_RUN     = 2'd0,
      MODE_DFREEZE = 2'd1,
      MODE_IFREEZE = 2'd2,
      MODE_BUBBLE  = 2'd3
   } mode_e;

   localparam int RUN_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [RUN_W-1:0] TIMEOUT_V = RUN_W'(TIMEOUT);

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v,
                                                    input logic en);
      if (en && (v != {CNT_W{1'b1}}))
         return v + CNT_W'(1);
      return v;
   endfunction

   function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
      if (v >= TIMEOUT_V)
         return v;
      return v + RUN_W'(1);
   endfunction

   mode_e            mode_d;
   logic             load_use;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
   logic             stall_timeout_q, stall_timeout_d;
   logic             freeze;

   // A load into r0 never creates a dependency.
   assign load_use = EX_CacheRead && (EX_rt != 5'd0) &&
                     ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));

   // Mode select and control decode. branch_taken only matters in RUN, so a
   // branch resolved under a stall is picked up again once the stall clears.
   always_comb begin
      mode_d     = MODE_RUN;
      PCWrite    = 1'b1;
      IFIDWrite  = 1'b1;
      IFID_flush = 1'b0;
      IDEX_hold  = 1'b0;
      IDEX_nop   = 1'b0;
      EXMEM_hold = 1'b0;
      MEMWB_hold = 1'b0;
      if (DCache_stall) begin
         mode_d     = MODE_DFREEZE;
         PCWrite    = 1'b0;
         IFIDWrite  = 1'b0;
         IDEX_hold  = 1'b1;
         EXMEM_hold = 1'b1;
         MEMWB_hold = 1'b1;
      end else if (ICache_stall) begin
         mode_d    = MODE_IFREEZE;
         PCWrite   = 1'b0;
         IFIDWrite = 1'b0;
         IDEX_nop  = 1'b1;
      end else if (load_use) begin
         mode_d    = MODE_BUBBLE;
         PCWrite   = 1'b0;
         IFIDWrite = 1'b0;
         IDEX_nop  = 1'b1;
      end else begin
         IFID_flush = branch_taken;
      end
   end

   // Counter next-state. Both freeze kinds share one run so a D-miss that
   // turns into an I-miss keeps accumulating toward the timeout.
   always_comb begin
      freeze          = (mode_d == MODE_DFREEZE) || (mode_d == MODE_IFREEZE);
      stall_cnt_d     = sat_inc_cnt(stall_cnt_q, freeze);
      bubble_cnt_d    = sat_inc_cnt(bubble_cnt_q, mode_d == MODE_BUBBLE);
      flush_cnt_d     = sat_inc_cnt(flush_cnt_q, IFID_flush);
      run_cnt_d       = freeze ? sat_inc_run(run_cnt_q) : '0;
      stall_timeout_d = stall_timeout_q || (run_cnt_d == TIMEOUT_V);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q          <= MODE_RUN;
         stall_cnt_q     <= '0;
         bubble_cnt_q    <= '0;
         flush_cnt_q     <= '0;
         run_cnt_q       <= '0;
         stall_timeout_q <= 1'b0;
      end else begin
         mode_q          <= mode_d;
         stall_cnt_q     <= stall_cnt_d;
         bubble_cnt_q    <= bubble_cnt_d;
         flush_cnt_q     <= flush_cnt_d;
         run_cnt_q       <= run_cnt_d;
         stall_timeout_q <= stall_timeout_d;
      end
   end

   assign stall_cnt     = stall_cnt_q;
   assign bubble_cnt    = bubble_cnt_q;
   assign flush_cnt     = flush_cnt_q;
   assign stall_timeout = stall_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: dut uses TIMEOUT=4/CNT_W=4; dut_def uses default parameters
// and shares all inputs.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] ID_rs = '0, ID_rt = '0, EX_rt = '0;
   logic       ID_uses_rt = 1'b0, EX_CacheRead = 1'b0, branch_taken = 1'b0;
   logic       ICache_stall = 1'b0, DCache_stall = 1'b0;

   logic       PCWrite, IFIDWrite, IFID_flush, IDEX_hold, IDEX_nop, EXMEM_hold, MEMWB_hold;
   logic [1:0] mode_q;
   logic [3:0] stall_cnt, bubble_cnt, flush_cnt;
   logic       stall_timeout;

   logic        d_PCWrite, d_IFIDWrite, d_IFID_flush, d_IDEX_hold, d_IDEX_nop, d_EXMEM_hold, d_MEMWB_hold;
   logic [1:0]  d_mode_q;
   logic [15:0] d_stall_cnt, d_bubble_cnt, d_flush_cnt;
   logic        d_stall_timeout;

   int checks = 0;
   int errors = 0;

   // {PCWrite, IFIDWrite, IFID_flush, IDEX_hold, IDEX_nop, EXMEM_hold, MEMWB_hold}
   logic [6:0] ctl;
   assign ctl = {PCWrite, IFIDWrite, IFID_flush, IDEX_hold, IDEX_nop, EXMEM_hold, MEMWB_hold};
   localparam logic [6:0] C_RUN    = 7'b1100000;
   localparam logic [6:0] C_RUN_BR = 7'b1110000;
   localparam logic [6:0] C_DFRZ   = 7'b0001011;
   localparam logic [6:0] C_NOP    = 7'b0000100;

   pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
      .EX_CacheRead(EX_CacheRead), .EX_rt(EX_rt), .branch_taken(branch_taken),
      .ICache_stall(ICache_stall), .DCache_stall(DCache_stall),
      .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFID_flush(IFID_flush),
      .IDEX_hold(IDEX_hold), .IDEX_nop(IDEX_nop), .EXMEM_hold(EXMEM_hold),
      .MEMWB_hold(MEMWB_hold), .mode_q(mode_q), .stall_cnt(stall_cnt),
      .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt), .stall_timeout(stall_timeout)
   );

   pipeline_hazard_ctrl dut_def (
      .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
      .EX_CacheRead(EX_CacheRead), .EX_rt(EX_rt), .branch_taken(branch_taken),
      .ICache_stall(ICache_stall), .DCache_stall(DCache_stall),
      .PCWrite(d_PCWrite), .IFIDWrite(d_IFIDWrite), .IFID_flush(d_IFID_flush),
      .IDEX_hold(d_IDEX_hold), .IDEX_nop(d_IDEX_nop), .EXMEM_hold(d_EXMEM_hold),
      .MEMWB_hold(d_MEMWB_hold), .mode_q(d_mode_q), .stall_cnt(d_stall_cnt),
      .bubble_cnt(d_bubble_cnt), .flush_cnt(d_flush_cnt), .stall_timeout(d_stall_timeout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ID_rs = '0; ID_rt = '0; EX_rt = '0; ID_uses_rt = 1'b0; EX_CacheRead = 1'b0;
      branch_taken = 1'b0; ICache_stall = 1'b0; DCache_stall = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      step();
      checks++;
      if ({mode_q, stall_cnt, bubble_cnt, flush_cnt, stall_timeout} !== 15'd0) begin
         errors++;
         $display("FAIL reset_state: got mode=%0d st=%0d bu=%0d fl=%0d to=%0d required all 0",
                  mode_q, stall_cnt, bubble_cnt, flush_cnt, stall_timeout);
      end
      DCache_stall = 1'b1;
      #1;
      checks++;
      if (ctl !== C_DFRZ) begin
         errors++;
         $display("FAIL reset_comb_dfreeze: got %b required %b", ctl, C_DFRZ);
      end
      step();
      checks++;
      if (mode_q !== 2'd0 || stall_cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset_holds_state: got mode=%0d st=%0d required 0 0", mode_q, stall_cnt);
      end
      rst_n = 1'b1;
      clear_inputs();
      #1;
   endtask

   task automatic test_load_use();
      do_reset();
      EX_CacheRead = 1'b1; EX_rt = 5'd8; ID_rs = 5'd8;
      #1;
      checks++;
      if (ctl !== C_NOP) begin
         errors++;
         $display("FAIL load_use_rs_ctl: got %b required %b", ctl, C_NOP);
      end
      step();
      checks++;
      if (bubble_cnt !== 4'd1 || mode_q !== 2'd3) begin
         errors++;
         $display("FAIL load_use_cnt: got bu=%0d mode=%0d required 1 3", bubble_cnt, mode_q);
      end
      EX_CacheRead = 1'b0;
      #1;
      checks++;
      if (ctl !== C_RUN) begin
         errors++;
         $display("FAIL load_use_release: got %b required %b", ctl, C_RUN);
      end
      step();
      checks++;
      if (mode_q !== 2'd0 || bubble_cnt !== 4'd1) begin
         errors++;
         $display("FAIL load_use_after: got mode=%0d bu=%0d required 0 1", mode_q, bubble_cnt);
      end
      // rt dependency counts only when ID actually reads rt
      EX_CacheRead = 1'b1; EX_rt = 5'd12; ID_rs = 5'd3; ID_rt = 5'd12; ID_uses_rt = 1'b1;
      #1;
      checks++;
      if (ctl !== C_NOP) begin
         errors++;
         $display("FAIL load_use_rt_ctl: got %b required %b", ctl, C_NOP);
      end
      clear_inputs();
      #1;
   endtask

   task automatic test_no_bubble();
      do_reset();
      EX_CacheRead = 1'b1; EX_rt = 5'd0; ID_rs = 5'd0;
      #1;
      checks++;
      if (ctl !== C_RUN) begin
         errors++;
         $display("FAIL no_bubble_r0: got %b required %b", ctl, C_RUN);
      end
      step();
      EX_rt = 5'd9; ID_rt = 5'd9; ID_rs = 5'd1; ID_uses_rt = 1'b0;
      #1;
      checks++;
      if (ctl !== C_RUN) begin
         errors++;
         $display("FAIL no_bubble_rt_unused: got %b required %b", ctl, C_RUN);
      end
      step();
      checks++;
      if (bubble_cnt !== 4'd0 || mode_q !== 2'd0) begin
         errors++;
         $display("FAIL no_bubble_cnt: got bu=%0d mode=%0d required 0 0", bubble_cnt, mode_q);
      end
      clear_inputs();
   endtask

   task automatic test_dfreeze();
      int bad = 0;
      do_reset();
      DCache_stall = 1'b1; ICache_stall = 1'b1; branch_taken = 1'b1;
      EX_CacheRead = 1'b1; EX_rt = 5'd8; ID_rs = 5'd8;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (ctl !== C_DFRZ) bad++;
         step();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL dfreeze_ctl: got %0d bad cycles required 0 (last %b vs %b)", bad, ctl, C_DFRZ);
      end
      checks++;
      if (stall_cnt !== 4'd5 || mode_q !== 2'd1 || bubble_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
         errors++;
         $display("FAIL dfreeze_cnt: got st=%0d mode=%0d bu=%0d fl=%0d required 5 1 0 0",
                  stall_cnt, mode_q, bubble_cnt, flush_cnt);
      end
      checks++;
      if (stall_timeout !== 1'b1 || d_stall_timeout !== 1'b0 || d_stall_cnt !== 16'd5) begin
         errors++;
         $display("FAIL dfreeze_timeout: got to=%0d def_to=%0d def_st=%0d required 1 0 5",
                  stall_timeout, d_stall_timeout, d_stall_cnt);
      end
      clear_inputs();
   endtask

   task automatic test_ifreeze_branch();
      int bad = 0;
      do_reset();
      ICache_stall = 1'b1; branch_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (ctl !== C_NOP) bad++;
         step();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL ifreeze_ctl: got %0d bad cycles required 0", bad);
      end
      ICache_stall = 1'b0;
      #1;
      checks++;
      if (ctl !== C_RUN_BR) begin
         errors++;
         $display("FAIL ifreeze_release_flush: got %b required %b", ctl, C_RUN_BR);
      end
      step();
      branch_taken = 1'b0;
      step();
      checks++;
      if (flush_cnt !== 4'd1 || stall_cnt !== 4'd3 || stall_timeout !== 1'b0) begin
         errors++;
         $display("FAIL ifreeze_cnt: got fl=%0d st=%0d to=%0d required 1 3 0",
                  flush_cnt, stall_cnt, stall_timeout);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      DCache_stall = 1'b1;
      step(); step();
      DCache_stall = 1'b0; ICache_stall = 1'b1;
      step();
      checks++;
      if (stall_timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: got %0d required 0", stall_timeout);
      end
      step();
      checks++;
      if (stall_timeout !== 1'b1) begin
         errors++;
         $display("FAIL timeout_set: got %0d required 1", stall_timeout);
      end
      clear_inputs();
      #1;
      checks++;
      if (ctl !== C_RUN) begin
         errors++;
         $display("FAIL timeout_no_ctl_effect: got %b required %b", ctl, C_RUN);
      end
      step(); step(); step();
      checks++;
      if (stall_timeout !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky: got %0d required 1", stall_timeout);
      end
      do_reset();
      checks++;
      if (stall_timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_reset: got %0d required 0", stall_timeout);
      end
      // a RUN cycle between freezes restarts the run
      DCache_stall = 1'b1;
      step(); step(); step();
      DCache_stall = 1'b0;
      step();
      ICache_stall = 1'b1;
      step(); step(); step();
      checks++;
      if (stall_timeout !== 1'b0 || stall_cnt !== 4'd6) begin
         errors++;
         $display("FAIL timeout_run_clears: got to=%0d st=%0d required 0 6", stall_timeout, stall_cnt);
      end
      clear_inputs();
   endtask

   task automatic test_saturation();
      do_reset();
      EX_CacheRead = 1'b1; EX_rt = 5'd4; ID_rs = 5'd4;
      for (int i = 0; i < 20; i++) step();
      checks++;
      if (bubble_cnt !== 4'd15) begin
         errors++;
         $display("FAIL bubble_saturate: got %0d required 15", bubble_cnt);
      end
      checks++;
      if (d_bubble_cnt !== 16'd20) begin
         errors++;
         $display("FAIL bubble_default_width: got %0d required 20", d_bubble_cnt);
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      DCache_stall = 1'b1;
      step(); step();
      rst_n = 1'b0;
      step();
      checks++;
      if (mode_q !== 2'd0 || stall_cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset_mid_stall: got mode=%0d st=%0d required 0 0", mode_q, stall_cnt);
      end
      rst_n = 1'b1;
      DCache_stall = 1'b0;
      step();
      checks++;
      if (mode_q !== 2'd0 || stall_cnt !== 4'd0) begin
         errors++;
         $display("FAIL after_mid_reset: got mode=%0d st=%0d required 0 0", mode_q, stall_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_bubble();
      test_dfreeze();
      test_ifreeze_branch();
      test_timeout();
      test_saturation();
      test_reset_mid_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameters SHALL be: TIMEOUT, default 1023, max consecutive stall cycles before error; CNT_W, default 16, performance counter width.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ID_rs, ID_rt  input  5 each  source registers of the instruction in ID.
REQ-005 ID_uses_rt  input  1  ID instruction reads rt as a source.
REQ-006 EX_CacheRead, EX_rt  input  1, 5  EX instruction is a load; its destination register.
REQ-007 branch_taken  input  1  branch/jump resolved taken in ID this cycle.
REQ-008 ICache_stall, DCache_stall  input  1 each  cache miss in progress.
REQ-009 PCWrite, IFIDWrite  output  1 each  1 = PC / IF-ID register may update.
REQ-010 IFID_flush  output  1  IF/ID loads a nop.
REQ-011 IDEX_hold, IDEX_nop  output  1 each  ID/EX keeps contents; ID/EX control fields zeroed.
REQ-012 EXMEM_hold, MEMWB_hold  output  1 each  later pipeline registers keep contents.
REQ-013 mode_q  output  2  registered mode: 0 RUN, 1 DFREEZE, 2 IFREEZE, 3 BUBBLE.
REQ-014 stall_cnt, bubble_cnt, flush_cnt  output  CNT_W each  saturating performance counters.
REQ-015 stall_timeout  output  1  sticky error flag.

Function
REQ-016 load_use SHALL be EX_CacheRead && EX_rt!=0 && (EX_rt==ID_rs || (ID_uses_rt && EX_rt==ID_rt)).
REQ-017 Mode SHALL be selected combinationally each cycle, in priority order: DCache_stall -> DFREEZE; ICache_stall -> IFREEZE; load_use -> BUBBLE; otherwise RUN.
REQ-018 DFREEZE SHALL drive PCWrite=0, IFIDWrite=0, IDEX_hold=1, EXMEM_hold=1, MEMWB_hold=1, IDEX_nop=0, IFID_flush=0.
REQ-019 IFREEZE SHALL drive PCWrite=0, IFIDWrite=0, IDEX_nop=1, with all holds 0 and IFID_flush=0.
REQ-020 BUBBLE SHALL drive PCWrite=0, IFIDWrite=0, IDEX_nop=1, with all holds 0 and IFID_flush=0.
REQ-021 RUN SHALL drive PCWrite=1, IFIDWrite=1, IFID_flush=branch_taken, with IDEX_nop and all holds 0.
REQ-022 branch_taken SHALL be ignored in every mode except RUN; it is re-evaluated when the held instruction is released.
REQ-023 IDEX_hold and IDEX_nop SHALL never be 1 in the same cycle.
REQ-024 Outputs in REQ-018..021 SHALL have zero-cycle latency (combinational from inputs).
REQ-025 mode_q SHALL register the selected mode every cycle, one cycle delayed.
REQ-026 stall_cnt SHALL increment once per cycle in DFREEZE or IFREEZE; bubble_cnt per BUBBLE cycle; flush_cnt per cycle with IFID_flush=1.
REQ-027 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 A run counter SHALL count consecutive DFREEZE/IFREEZE cycles, clear on any other mode, and saturate at TIMEOUT.
REQ-029 stall_timeout SHALL set when the run counter reaches TIMEOUT and remain 1 until reset; it SHALL NOT alter pipeline control outputs.
REQ-030 A DFREEZE to IFREEZE transition SHALL continue the run count without clearing it.

Reset
REQ-031 While rst_n=0 at a clock edge, the block SHALL clear mode_q to 0, all counters to 0, the run counter to 0, and stall_timeout to 0.
REQ-032 Combinational outputs during reset SHALL follow REQ-017..021 from the current inputs.
REQ-033 Reset asserted mid-stall SHALL clear state at that edge; mode_q=0 on the following cycle regardless of inputs.

Verification
REQ-034 Load-use: EX_CacheRead=1, EX_rt=8, ID_rs=8 -> PCWrite=0, IFIDWrite=0, IDEX_nop=1 for 1 cycle; bubble_cnt=1; next cycle (EX_CacheRead=0) RUN.
REQ-035 EX_rt=0 with ID_rs=0, EX_CacheRead=1 -> no bubble, RUN; EX_rt=9, ID_rt=9, ID_uses_rt=0 -> no bubble.
REQ-036 DCache_stall=1 for 5 cycles with load_use=1 and branch_taken=1 -> all holds=1, IDEX_nop=0, IFID_flush=0 each cycle; stall_cnt=5.
REQ-037 ICache_stall=1 for 3 cycles with branch_taken=1 -> IDEX_nop=1, IFID_flush=0; on release, IFID_flush=1 for 1 cycle; flush_cnt=1.
REQ-038 TIMEOUT=4, DCache_stall=1 for 2 cycles then ICache_stall=1 for 2 cycles -> stall_timeout=1; it stays 1 after stalls end, until rst_n=0.
REQ-039 Counter saturation, CNT_W=4: 20 bubble cycles -> bubble_cnt=15.
